// File: rtl/if_fetch_queue_pkg.sv
// Shared types and constants for the instruction-fetch prefetch queue.
package if_fetch_queue_pkg;

  localparam int                   FQ_XLEN     = 32;
  localparam logic [FQ_XLEN-1:0]   FQ_RESET_PC = 32'h0000_0000;
  localparam logic [FQ_XLEN-1:0]   FQ_NOP      = 32'h0000_0013;

  // One queued fetch: the PC it was fetched from and the returned word.
  typedef struct packed {
    logic [FQ_XLEN-1:0] pc;
    logic [FQ_XLEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fq_ring_buffer.sv
// DEPTH-entry circular buffer of fetch entries with a single-cycle clear.
// The caller only asserts rd_en when the buffer is non-empty; clear beats
// any write or read issued in the same cycle.
module fq_ring_buffer
  import if_fetch_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = PW + 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         wr_en,
  input  fetch_entry_t wr_data,
  input  logic         rd_en,
  output fetch_entry_t rd_data,
  output logic [CW-1:0] count
);

  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  fetch_entry_t  mem_q [DEPTH];

  // Next-state pointers and count; pointers wrap naturally at DEPTH (power of two).
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (clear) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (wr_en) tail_d = tail_q + PW'(1);
      if (rd_en) head_d = head_q + PW'(1);
      count_d = count_q + CW'(wr_en) - CW'(rd_en);
    end
  end

  // Pointer and count registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage array; contents are only meaningful where count says so.
  always_ff @(posedge clk) begin
    if (wr_en && !clear) mem_q[tail_q] <= wr_data;
  end

  assign rd_data = mem_q[head_q];
  assign count   = count_q;

  // Issue credits make a write into a full buffer impossible unless a read frees a slot.
  a_no_overflow : assert property (@(posedge clk) disable iff (rst)
    (wr_en && !clear) |-> ((count_q < CW'(DEPTH)) || rd_en));

endmodule

// File: rtl/if_fetch_queue.sv
// Instruction-fetch front end: owns the fetch PC, issues requests to a
// 1-cycle-latency instruction memory and buffers returned words in a
// DEPTH-entry prefetch queue. In-flight requests hold a credit so a response
// always has a slot. A redirect flushes the queue and cancels the pending response.
module if_fetch_queue
  import if_fetch_queue_pkg::*;
#(
  parameter int              DEPTH    = 4,
  parameter int              XLEN     = FQ_XLEN,
  parameter logic [XLEN-1:0] RESET_PC = FQ_RESET_PC,
  localparam int             CW       = $clog2(DEPTH) + 1
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            deq_ready,
  output logic            deq_valid,
  output logic [XLEN-1:0] deq_pc,
  output logic [XLEN-1:0] deq_instr,
  output logic [XLEN-1:0] fetch_pc,
  output logic [CW-1:0]   occupancy
);

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
  logic            rsp_valid_q, rsp_valid_d;
  fetch_entry_t    hold_q, hold_d;

  logic            deq_fire;
  logic            rb_wr_en;
  logic            occ_nz;
  logic [CW:0]     credits;
  fetch_entry_t    rb_wr_data;
  fetch_entry_t    rb_head;
  logic [CW-1:0]   rb_count;
  logic            unused_redirect_lsb;

  assign unused_redirect_lsb = ^redirect_pc[1:0];

  fq_ring_buffer #(.DEPTH(DEPTH)) u_ring (
    .clk     (clk),
    .rst     (rst),
    .clear   (redirect_valid),
    .wr_en   (rb_wr_en),
    .wr_data (rb_wr_data),
    .rd_en   (deq_fire),
    .rd_data (rb_head),
    .count   (rb_count)
  );

  // Issue decision, dequeue handshake and response write-back.
  always_comb begin
    occ_nz     = (rb_count != '0);
    deq_valid  = occ_nz && !redirect_valid;
    deq_fire   = deq_valid && deq_ready;
    credits    = {1'b0, rb_count} + (CW+1)'(rsp_valid_q) - (CW+1)'(deq_fire);
    // rst gates the request so it is low for the whole reset window, not just after the first edge.
    imem_req   = !rst && !redirect_valid && (credits < (CW+1)'(DEPTH));
    rb_wr_en   = rsp_valid_q && !redirect_valid;
    rb_wr_data = fetch_entry_t'{pc: rsp_pc_q, instr: imem_rdata};
  end

  // Next fetch PC, response tracking and the held head value shown while empty.
  always_comb begin
    fetch_pc_d  = fetch_pc_q;
    rsp_pc_d    = rsp_pc_q;
    rsp_valid_d = imem_req;
    hold_d      = occ_nz ? rb_head : hold_q;
    if (redirect_valid) begin
      fetch_pc_d = {redirect_pc[XLEN-1:2], 2'b00};
    end else if (imem_req) begin
      fetch_pc_d = fetch_pc_q + XLEN'(4);
      rsp_pc_d   = fetch_pc_q;
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q  <= RESET_PC;
      rsp_pc_q    <= '0;
      rsp_valid_q <= 1'b0;
      hold_q      <= '0;
    end else begin
      fetch_pc_q  <= fetch_pc_d;
      rsp_pc_q    <= rsp_pc_d;
      rsp_valid_q <= rsp_valid_d;
      hold_q      <= hold_d;
    end
  end

  assign imem_addr = fetch_pc_q;
  assign fetch_pc  = fetch_pc_q;
  assign occupancy = rb_count;
  assign deq_pc    = occ_nz ? rb_head.pc    : hold_q.pc;
  assign deq_instr = occ_nz ? rb_head.instr : hold_q.instr;

endmodule

// File: tb/tb_if_fetch_queue.sv
// Directed bench for if_fetch_queue: stimulus pushes the expected dequeue
// stream into a scoreboard; a monitor pops and compares on every dequeue.
module tb_if_fetch_queue;

  localparam int DEPTH = 4;
  localparam int XLEN  = 32;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic            clk;
  logic            rst;
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic [XLEN-1:0] imem_rdata;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            deq_ready;
  logic            deq_valid;
  logic [XLEN-1:0] deq_pc;
  logic [XLEN-1:0] deq_instr;
  logic [XLEN-1:0] fetch_pc;
  logic [CW-1:0]   occupancy;

  int n_tests = 0;
  int n_fail  = 0;
  logic [XLEN-1:0] sb[$];

  if_fetch_queue #(.DEPTH(DEPTH), .XLEN(XLEN), .RESET_PC(32'h0)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .deq_ready      (deq_ready),
    .deq_valid      (deq_valid),
    .deq_pc         (deq_pc),
    .deq_instr      (deq_instr),
    .fetch_pc       (fetch_pc),
    .occupancy      (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory contents: address-derived word, so instr and pc are distinguishable.
  function automatic logic [XLEN-1:0] mem_word(input logic [XLEN-1:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  initial imem_rdata = 32'h0000_0013;
  always @(posedge clk) imem_rdata <= imem_req ? mem_word(imem_addr) : 32'h0000_0013;

  task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: every dequeue must match the next expected entry.
  initial begin
    logic [XLEN-1:0] e;
    forever begin
      @(negedge clk);
      #2;
      if (!rst && deq_valid && deq_ready) begin
        if (sb.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL sb_unexpected: got pc %h, expected no dequeue", deq_pc);
        end else begin
          e = sb.pop_front();
          chk("sb_deq_pc", deq_pc, e);
          chk("sb_deq_instr", deq_instr, mem_word(e));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    @(negedge clk);
    deq_ready      = 1'b0;
    redirect_valid = 1'b0;
    rst            = 1'b1;
    @(negedge clk);
    chk("sb_drain", XLEN'(sb.size()), '0);
    sb.delete();
  endtask

  // Releases reset on a falling edge; the following rising edge ends "cycle 0".
  task automatic release_rst(input logic rdy);
    @(negedge clk);
    deq_ready = rdy;
    rst       = 1'b0;
  endtask

  task automatic push_stream(input logic [XLEN-1:0] base, input int n);
    for (int k = 0; k < n; k++) sb.push_back(base + XLEN'(4 * k));
  endtask

  initial begin
    int nreq;
    rst            = 1'b1;
    deq_ready      = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    #1;
    chk("rst_imem_req",  XLEN'(imem_req),  '0);
    chk("rst_deq_valid", XLEN'(deq_valid), '0);
    chk("rst_deq_pc",    deq_pc,           '0);
    chk("rst_deq_instr", deq_instr,        '0);
    chk("rst_occupancy", XLEN'(occupancy), '0);
    chk("rst_fetch_pc",  fetch_pc,         '0);

    // Streaming: one request per cycle, first dequeue two cycles after first request.
    do_reset();
    push_stream(32'h0, 10);
    release_rst(1'b1);
    for (int i = 0; i < 12; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      chk("stream_req",  XLEN'(imem_req), 32'h1);
      chk("stream_addr", imem_addr, XLEN'(4 * i));
      chk("stream_deq_valid", XLEN'(deq_valid), XLEN'(i >= 2));
      if (i >= 2) chk("stream_deq_pc", deq_pc, XLEN'(4 * (i - 2)));
    end

    // Stall until full, then release with dequeue+issue every cycle.
    do_reset();
    release_rst(1'b0);
    nreq = 0;
    for (int i = 0; i < 10; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      if (imem_req) nreq++;
    end
    chk("full_req_count", XLEN'(nreq), 32'd4);
    chk("full_occupancy", XLEN'(occupancy), 32'd4);
    chk("full_req_low",   XLEN'(imem_req), 32'd0);
    chk("full_fetch_pc",  fetch_pc, 32'd16);
    push_stream(32'h0, 20);
    for (int i = 10; i < 30; i++) begin
      @(negedge clk);
      deq_ready = 1'b1;
      #1;
      chk("full_deq_valid", XLEN'(deq_valid), 32'd1);
      chk("full_issue", XLEN'(imem_req), 32'd1);
      chk("full_issue_addr", imem_addr, XLEN'(16 + 4 * (i - 10)));
      // After the first freed slot, one slot is always held by the in-flight credit.
      chk("full_occ_steady", XLEN'(occupancy), (i == 10) ? 32'd4 : 32'd3);
    end

    // Redirect with 3 queued + 1 in flight.
    do_reset();
    release_rst(1'b0);
    repeat (4) @(negedge clk);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    deq_ready      = 1'b1;
    #1;
    chk("redir_occ_before", XLEN'(occupancy), 32'd3);
    chk("redir_req_low",    XLEN'(imem_req),  32'd0);
    chk("redir_deq_forced", XLEN'(deq_valid), 32'd0);
    push_stream(32'h100, 5);
    @(negedge clk);
    redirect_valid = 1'b0;
    #1;
    chk("redir_occ_cleared", XLEN'(occupancy), 32'd0);
    chk("redir_req",         XLEN'(imem_req),  32'd1);
    chk("redir_addr",        imem_addr,        32'h100);
    @(negedge clk);
    #1;
    chk("redir_no_stale", XLEN'(occupancy), 32'd0);
    for (int i = 7; i < 12; i++) begin
      @(negedge clk);
      #1;
      chk("redir_deq_valid", XLEN'(deq_valid), 32'd1);
    end

    // Back-to-back redirects: the last target wins.
    do_reset();
    sb.push_back(32'h0);
    sb.push_back(32'h4);
    push_stream(32'h300, 5);
    release_rst(1'b1);
    repeat (3) @(negedge clk);
    @(negedge clk);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h200;
    #1;
    chk("b2b_req0",   XLEN'(imem_req),  32'd0);
    chk("b2b_deq0",   XLEN'(deq_valid), 32'd0);
    @(negedge clk);
    redirect_pc = 32'h300;
    #1;
    chk("b2b_req1",   XLEN'(imem_req),  32'd0);
    chk("b2b_pc1",    fetch_pc,         32'h200);
    @(negedge clk);
    redirect_valid = 1'b0;
    #1;
    chk("b2b_addr",   imem_addr,        32'h300);
    chk("b2b_req2",   XLEN'(imem_req),  32'd1);
    chk("b2b_occ",    XLEN'(occupancy), 32'd0);
    @(negedge clk);
    #1;
    chk("b2b_deq_gap", XLEN'(deq_valid), 32'd0);
    for (int i = 8; i < 13; i++) begin
      @(negedge clk);
      #1;
      chk("b2b_deq_valid", XLEN'(deq_valid), 32'd1);
    end

    // Asynchronous reset mid-stream with 2 entries queued.
    do_reset();
    release_rst(1'b0);
    repeat (3) @(negedge clk);
    #1;
    chk("mid_occ_before", XLEN'(occupancy), 32'd2);
    rst = 1'b1;
    #1;
    chk("mid_imem_req",  XLEN'(imem_req),  '0);
    chk("mid_deq_valid", XLEN'(deq_valid), '0);
    chk("mid_deq_pc",    deq_pc,           '0);
    chk("mid_deq_instr", deq_instr,        '0);
    chk("mid_occupancy", XLEN'(occupancy), '0);
    chk("mid_fetch_pc",  fetch_pc,         '0);
    push_stream(32'h0, 6);
    release_rst(1'b1);
    #1;
    chk("mid_restart_addr", imem_addr, 32'h0);
    chk("mid_restart_req",  XLEN'(imem_req), 32'd1);
    @(negedge clk);
    #1;
    chk("mid_no_stale", XLEN'(occupancy), 32'd0);
    repeat (6) @(negedge clk);

    // Unaligned redirect target near the top of the address space: low bits dropped, PC wraps.
    do_reset();
    sb.push_back(32'hFFFF_FFF8);
    sb.push_back(32'hFFFF_FFFC);
    push_stream(32'h0, 2);
    release_rst(1'b1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFA;
    #1;
    chk("wrap_req_low", XLEN'(imem_req), 32'd0);
    @(negedge clk);
    redirect_valid = 1'b0;
    #1;
    chk("wrap_addr0", imem_addr, 32'hFFFF_FFF8);
    @(negedge clk);
    #1;
    chk("wrap_addr1", imem_addr, 32'hFFFF_FFFC);
    @(negedge clk);
    #1;
    chk("wrap_addr2", imem_addr, 32'h0);
    repeat (4) @(negedge clk);
    deq_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("final_drain", XLEN'(sb.size()), '0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
